// File: rtl/edge_detect_multi_pkg.sv
// rtl/edge_detect_multi_pkg.sv - shared types for the multi-channel edge detector
//
// Purpose: edge mode and debounce state enumerations, plus the helper that
//          decides whether an accepted edge of a given direction produces a
//          tick under a given mode.
// Ports:   none (package)

package edge_detect_pkg;

  typedef enum bit [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_t;

  typedef enum bit [1:0] {
    S_LOW    = 2'd0,
    S_CHK_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_CHK_LO = 2'd3
  } deb_state_t;

  function automatic logic mode_allows(input edge_mode_t m, input logic rising);
    if (m == EDGE_BOTH) return 1'b1;
    if (rising)         return (m == EDGE_RISE);
    return (m == EDGE_FALL);
  endfunction

endpackage

// File: rtl/edge_detect_multi_channel.sv
// rtl/edge_detect_multi_channel.sv - one channel: synchroniser, debounce FSM, tick, pending
//
// Purpose: brings one asynchronous level into the CLK domain, requires the new
//          level to hold for DEBOUNCE_CYCLES synced cycles before accepting it,
//          and reports accepted edges as a Mealy tick plus a sticky pending flag.
// Ports:   CLK     - clock, rising edge
//          reset   - asynchronous, active-high
//          level   - raw asynchronous input level
//          mode    - edge_mode_t selecting which accepted edges tick
//          clr     - synchronous clear of pending (tick in the same cycle wins)
//          tick    - one-cycle pulse during the accept cycle
//          stable  - debounced level
//          pending - sticky event flag

module edge_channel
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       level,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       tick,
  output logic       stable,
  output logic       pending
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            DEB_ONE  = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] r_sync;
  deb_state_t             r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_pending;

  logic       w_s;
  logic       w_accept_rise;
  logic       w_accept_fall;
  logic       w_tick;
  edge_mode_t w_mode;

  assign w_mode = edge_mode_t'(mode);
  assign w_s    = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], level};
  end

  // Accept fires in the cycle that holds the DEBOUNCE_CYCLES-th consecutive
  // sample of the new level; with a single-cycle debounce that is the first.
  always_comb begin
    w_accept_rise = 1'b0;
    w_accept_fall = 1'b0;
    case (r_state)
      S_LOW:    w_accept_rise = w_s && DEB_ONE;
      S_CHK_HI: w_accept_rise = w_s && (r_cnt == CNT_LAST);
      S_HIGH:   w_accept_fall = !w_s && DEB_ONE;
      S_CHK_LO: w_accept_fall = !w_s && (r_cnt == CNT_LAST);
      default: ;
    endcase
  end

  assign w_tick = !reset &&
                  ((w_accept_rise && mode_allows(w_mode, 1'b1)) ||
                   (w_accept_fall && mode_allows(w_mode, 1'b0)));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_LOW: if (w_s) begin
          if (w_accept_rise) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
          end else begin
            r_state <= S_CHK_HI;
            r_cnt   <= CNT_ONE;
          end
        end
        S_CHK_HI: begin
          if (!w_s) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else if (w_accept_rise) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_HIGH: if (!w_s) begin
          if (w_accept_fall) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else begin
            r_state <= S_CHK_LO;
            r_cnt   <= CNT_ONE;
          end
        end
        S_CHK_LO: begin
          if (w_s) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
          end else if (w_accept_fall) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= S_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Set has priority so a clear issued alongside a new event never loses it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)       r_pending <= 1'b0;
    else if (w_tick) r_pending <= 1'b1;
    else if (clr)    r_pending <= 1'b0;
  end

  assign tick    = w_tick;
  assign stable  = (r_state == S_HIGH) || (r_state == S_CHK_LO);
  assign pending = r_pending;

endmodule

// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - multi-channel debounced edge detector top
//
// Purpose: CHANNELS independent edge_channel instances plus the OR of their
//          pending flags.
// Ports:   CLK         - clock, rising edge
//          reset       - asynchronous, active-high
//          level       - [CHANNELS] raw asynchronous levels
//          mode        - [2*CHANNELS] edge_mode_t per channel, bits [2i+1:2i]
//          clr         - [CHANNELS] pending clears
//          tick        - [CHANNELS] one-cycle edge pulses (combinational)
//          stable      - [CHANNELS] debounced levels
//          pending     - [CHANNELS] sticky event flags
//          any_pending - OR of pending

module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   level,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   tick,
  output logic [CHANNELS-1:0]   stable,
  output logic [CHANNELS-1:0]   pending,
  output logic                  any_pending
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .CLK    (CLK),
      .reset  (reset),
      .level  (level[g]),
      .mode   (mode[2*g +: 2]),
      .clr    (clr[g]),
      .tick   (tick[g]),
      .stable (stable[g]),
      .pending(pending[g])
    );
  end

  assign any_pending = |pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// tb/tb_edge_detect_multi.sv - self-checking bench for edge_detect_multi

module tb_edge_detect_multi;
  import edge_detect_pkg::*;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic            CLK = 1'b0;
  logic            reset;
  logic [CH-1:0]   level;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   stable;
  logic [CH-1:0]   pending;
  logic            any_pending;

  int n_pass  = 0;
  int n_total = 0;

  // Reference: a delay line of raw samples, the debounced level, and the
  // length of the current run of synced samples that disagree with it.
  bit            m_stable[CH];
  int            m_run[CH];
  bit            m_pend[CH];
  bit            m_pipe[CH][$];
  logic [CH-1:0] last_tick;

  always #5 CLK = ~CLK;

  edge_detect_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK(CLK), .reset(reset), .level(level), .mode(mode), .clr(clr),
    .tick(tick), .stable(stable), .pending(pending), .any_pending(any_pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit allows(input logic [1:0] m, input bit rising);
    if (m == 2'(EDGE_BOTH)) return 1'b1;
    return rising ? (m == 2'(EDGE_RISE)) : (m == 2'(EDGE_FALL));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_stable[c] = 1'b0;
      m_run[c]    = 0;
      m_pend[c]   = 1'b0;
      m_pipe[c].delete();
      repeat (SYNC) m_pipe[c].push_back(1'b0);
    end
  endtask

  task automatic set_mode(input int c, input edge_mode_t m);
    mode[2*c +: 2] = 2'(m);
  endtask

  // Called at a falling edge with inputs already driven; checks this cycle
  // and advances the reference across the next rising edge.
  task automatic cycle(input string tag);
    logic [CH-1:0] e_tick, e_stable, e_pend;
    bit s;
    #1;
    if (reset) model_reset();
    for (int c = 0; c < CH; c++) begin
      s           = m_pipe[c][0];
      e_tick[c]   = !reset && (s != m_stable[c]) && (m_run[c] + 1 >= DEB) &&
                    allows(mode[2*c +: 2], s);
      e_stable[c] = m_stable[c];
      e_pend[c]   = m_pend[c];
    end
    chk({tag, "/tick"},        32'(tick),    32'(e_tick));
    chk({tag, "/stable"},      32'(stable),  32'(e_stable));
    chk({tag, "/pending"},     32'(pending), 32'(e_pend));
    chk({tag, "/any_pending"}, 32'(any_pending), 32'(|e_pend));
    last_tick = tick;
    @(posedge CLK);
    if (reset) model_reset();
    else begin
      for (int c = 0; c < CH; c++) begin
        s = m_pipe[c][0];
        if (s != m_stable[c]) begin
          if (m_run[c] + 1 >= DEB) begin
            m_stable[c] = s;
            m_run[c]    = 0;
          end else m_run[c]++;
        end else m_run[c] = 0;
        if (e_tick[c])   m_pend[c] = 1'b1;
        else if (clr[c]) m_pend[c] = 1'b0;
        void'(m_pipe[c].pop_front());
        m_pipe[c].push_back(level[c]);
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    int first;
    int cnt;
    int cnts[CH];
    int g;

    reset = 1'b1;
    level = '0;
    clr   = '0;
    mode  = '0;
    model_reset();
    @(negedge CLK);
    repeat (2) cycle("reset");
    chk("reset/outputs", 32'({tick, stable, pending, any_pending}), 32'd0);
    reset = 1'b0;

    // 1: single rising edge on channel 0
    set_mode(0, EDGE_RISE);
    repeat (3) cycle("t1_idle");
    level[0] = 1'b1;
    first = -1;
    cnt   = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle("t1");
      if (last_tick[0] && first < 0) first = i;
      cnt += int'(last_tick[0]);
    end
    chk("t1/latency", 32'(first), 32'd6);
    chk("t1/count", 32'(cnt), 32'd1);
    chk("t1/pending0", 32'(pending[0]), 32'd1);
    chk("t1/stable0", 32'(stable[0]), 32'd1);

    // 2: glitch shorter than the debounce, then a minimum-length pulse
    set_mode(1, EDGE_BOTH);
    g = $urandom_range(1, DEB - 1);
    level[1] = 1'b1;
    cnt = 0;
    repeat (g) begin cycle("t2_glitch"); cnt += int'(last_tick[1]); end
    level[1] = 1'b0;
    repeat (10) begin cycle("t2_glitch"); cnt += int'(last_tick[1]); end
    chk("t2/glitch_ticks", 32'(cnt), 32'd0);
    chk("t2/glitch_stable", 32'(stable[1]), 32'd0);
    level[1] = 1'b1;
    cnt = 0;
    repeat (DEB) begin cycle("t2_pulse"); cnt += int'(last_tick[1]); end
    level[1] = 1'b0;
    repeat (12) begin cycle("t2_pulse"); cnt += int'(last_tick[1]); end
    chk("t2/pulse_ticks", 32'(cnt), 32'd2);

    // 3: falling-only mode, then off while stable keeps tracking
    set_mode(2, EDGE_FALL);
    cnt = 0;
    repeat (4) begin
      level[2] = ~level[2];
      repeat (10) begin cycle("t3_fall"); cnt += int'(last_tick[2]); end
    end
    chk("t3/fall_ticks", 32'(cnt), 32'd2);
    set_mode(2, EDGE_OFF);
    cnt = 0;
    repeat (3) begin
      level[2] = ~level[2];
      repeat (10) begin cycle("t3_off"); cnt += int'(last_tick[2]); end
    end
    chk("t3/off_ticks", 32'(cnt), 32'd0);
    chk("t3/off_stable", 32'(stable[2]), 32'(level[2]));

    // 4: clear coinciding with a tick loses nothing; next clear works
    clr = '1;
    cycle("t4_clrall");
    clr = '0;
    chk("t4/any_cleared", 32'(any_pending), 32'd0);
    level[0] = 1'b0;
    repeat (10) cycle("t4_fall");
    level[0] = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      clr[0] = (i == 6 || i == 7);
      cycle("t4");
      if (i == 6) begin
        chk("t4/tick", 32'(last_tick[0]), 32'd1);
        chk("t4/set_wins", 32'(pending[0]), 32'd1);
      end
      if (i == 7) begin
        chk("t4/cleared", 32'(pending[0]), 32'd0);
        chk("t4/any_zero", 32'(any_pending), 32'd0);
      end
    end
    clr = '0;

    // 5: reset in the middle of a debounce, released high and then low
    for (int c = 0; c < CH; c++) set_mode(c, EDGE_BOTH);
    level[3] = 1'b1;
    repeat (3) cycle("t5_pre");
    reset = 1'b1;
    repeat (2) cycle("t5_rst");
    chk("t5/rst_outputs", 32'({tick, stable, pending, any_pending}), 32'd0);
    reset = 1'b0;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle("t5_high");
      if (last_tick[3] && first < 0) first = i;
    end
    chk("t5/high_latency", 32'(first), 32'd6);
    level[3] = 1'b0;
    reset    = 1'b1;
    repeat (2) cycle("t5_rst2");
    reset = 1'b0;
    cnt = 0;
    repeat (10) begin cycle("t5_low"); cnt += int'(last_tick[3]); end
    chk("t5/low_ticks", 32'(cnt), 32'd0);

    // 6: all channels switch together under RISE/FALL/BOTH/OFF
    set_mode(0, EDGE_RISE);
    set_mode(1, EDGE_FALL);
    set_mode(2, EDGE_BOTH);
    set_mode(3, EDGE_OFF);
    level = '0;
    repeat (10) cycle("t6_settle");
    for (int c = 0; c < CH; c++) cnts[c] = 0;
    repeat (6) begin
      level = ~level;
      repeat ($urandom_range(6, 12)) begin
        cycle("t6");
        for (int c = 0; c < CH; c++) cnts[c] += int'(last_tick[c]);
      end
    end
    chk("t6/rise_ticks", 32'(cnts[0]), 32'd3);
    chk("t6/fall_ticks", 32'(cnts[1]), 32'd3);
    chk("t6/both_ticks", 32'(cnts[2]), 32'd6);
    chk("t6/off_ticks",  32'(cnts[3]), 32'd0);

    // random soak against the reference
    repeat (1500) begin
      if ($urandom_range(0, 31) == 0) mode = 8'($urandom);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) level[c] = ~level[c];
      clr   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      reset = ($urandom_range(0, 199) == 0);
      cycle("rand");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
